// File: rtl/image_frame_receiver.sv
// image_frame_receiver
// Assembles a 196-bit binary image from 28 seven-bit chunks streamed by the
// host. The host frames each image with frame_en. The finished image is
// handed to the inference datapath with a ready/ack handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a rising edge on frame_en
// RECV   | capturing one chunk per cycle while frame_en stays high
// READY  | image complete and frozen; waiting for image_ack
module image_frame_receiver #(
    parameter int DATA_W = 7,
    parameter int CHUNKS = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     frame_en,
    input  logic                     image_ack,
    output logic [DATA_W*CHUNKS-1:0] image_data,
    output logic                     image_ready,
    output logic                     busy,
    output logic                     frame_error
);

    localparam int IMG_W = DATA_W * CHUNKS;
    localparam logic [4:0] LAST_CHUNK = 5'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [4:0]         cnt_q,         cnt_d;
    logic               frame_en_q,    frame_en_d;
    logic [IMG_W-1:0]   image_q,       image_d;
    logic               ready_q,       ready_d;
    logic               busy_q,        busy_d;
    logic               err_q,         err_d;
    logic               start;

    assign start = frame_en && !frame_en_q;

    // Next-state and capture logic; every output is a flop, so the
    // handshake signals are computed here one cycle ahead.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_en_d = frame_en;
        image_d    = image_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    image_d[DATA_W-1:0] = data_in;
                    cnt_d   = 5'd1;
                    busy_d  = 1'b1;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (frame_en) begin
                    image_d[int'(cnt_q)*DATA_W +: DATA_W] = data_in;
                    if (cnt_q == LAST_CHUNK) begin
                        cnt_d   = 5'd0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = S_READY;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    // The partial image is left in place; it is simply
                    // never flagged valid.
                    cnt_d   = 5'd0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_READY: begin
                // A start edge seen here is consumed by frame_en_q, so the
                // host must drop and re-raise frame_en after the ack.
                if (image_ack) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 5'd0;
                busy_d  = 1'b0;
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register all state. During reset frame_en_q still tracks frame_en,
    // so a frame_en held high across reset release cannot look like a start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            frame_en_q <= frame_en;
            image_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_en_q <= frame_en_d;
            image_q    <= image_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign image_data  = image_q;
    assign image_ready = ready_q;
    assign busy        = busy_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_image_frame_receiver.sv
// Testbench for image_frame_receiver: directed scenarios plus randomized
// frames. Expected images come from a pixel-level model and are queued
// for a monitor that checks them independently of the stimulus.
module tb_image_frame_receiver;

    localparam int DW = 7;
    localparam int NC = 28;
    localparam int IW = DW * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          frame_en;
    logic          image_ack;
    logic [IW-1:0] image_data;
    logic          image_ready;
    logic          busy;
    logic          frame_error;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_img_q[$];
    int            exp_err_q[$];
    logic [IW-1:0] held_img = '0;
    logic          prev_ready = 1'b0;
    logic          prev_err = 1'b0;
    logic [DW-1:0] ch[NC];

    always #5 clk = ~clk;

    image_frame_receiver #(.DATA_W(DW), .CHUNKS(NC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .frame_en    (frame_en),
        .image_ack   (image_ack),
        .image_data  (image_data),
        .image_ready (image_ready),
        .busy        (busy),
        .frame_error (frame_error)
    );

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pixel p = row*14 + col. Columns 0..6 of a row travel in chunk 2*row,
    // columns 7..13 in chunk 2*row+1, pixel column c%7 on data bit c%7.
    function automatic logic [IW-1:0] model_image();
        logic [IW-1:0] img;
        img = '0;
        for (int p = 0; p < IW; p++) begin
            int row, col, chunk;
            row   = p / 14;
            col   = p % 14;
            chunk = 2 * row + ((col >= 7) ? 1 : 0);
            img[p] = ch[chunk][col % 7];
        end
        return img;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a new image or
    // an abort pulse; while ready stays high the image must not move.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ready = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (image_ready && !prev_ready) begin
                check("ready_expected", IW'(exp_img_q.size() > 0), IW'(1));
                if (exp_img_q.size() > 0) begin
                    held_img = exp_img_q.pop_front();
                    check("frame_image", image_data, held_img);
                end
            end else if (image_ready) begin
                check("frozen_image", image_data, held_img);
            end
            if (frame_error) begin
                check("error_width", IW'(prev_err), IW'(0));
                if (!prev_err) begin
                    check("error_expected", IW'(exp_err_q.size() > 0), IW'(1));
                    if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
                end
            end
            prev_ready = image_ready;
            prev_err   = frame_error;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends the first n chunks of ch[]. With n < NC and drop set, frame_en
    // falls after the n-th chunk to abort the frame.
    task automatic send_frame(input int n, input bit drop);
        if (n == NC) exp_img_q.push_back(model_image());
        for (int k = 0; k < n; k++) begin
            frame_en = 1'b1;
            data_in  = ch[k];
            step();
            if (k < NC - 1) check("busy_recv", IW'(busy), IW'(1));
            if (k == NC - 2) check("ready_early", IW'(image_ready), IW'(0));
        end
        if (n == NC) begin
            check("busy_after_last", IW'(busy), IW'(0));
            check("ready_latency", IW'(image_ready), IW'(1));
        end else if (drop) begin
            exp_err_q.push_back(1);
            frame_en = 1'b0;
            data_in  = DW'($urandom);
            step();
            check("abort_error", IW'(frame_error), IW'(1));
            check("abort_busy", IW'(busy), IW'(0));
            check("abort_ready", IW'(image_ready), IW'(0));
            step();
            check("abort_pulse_end", IW'(frame_error), IW'(0));
            check("abort_no_ready", IW'(image_ready), IW'(0));
        end
    endtask

    task automatic hold_ready(input int n, input bit rand_en);
        for (int i = 0; i < n; i++) begin
            data_in = DW'($urandom);
            if (rand_en) frame_en = 1'($urandom);
            step();
            check("ready_held", IW'(image_ready), IW'(1));
            check("busy_in_ready", IW'(busy), IW'(0));
        end
    endtask

    task automatic do_ack();
        image_ack = 1'b1;
        step();
        image_ack = 1'b0;
        check("ack_clears", IW'(image_ready), IW'(0));
        for (int i = 0; i < 2; i++) begin
            step();
            check("no_restart_busy", IW'(busy), IW'(0));
            check("no_restart_ready", IW'(image_ready), IW'(0));
        end
        frame_en = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, image_data, '0);
        check({tag, "_ready"}, IW'(image_ready), IW'(0));
        check({tag, "_busy"}, IW'(busy), IW'(0));
        check({tag, "_error"}, IW'(frame_error), IW'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        frame_en  = 1'b0;
        data_in   = '0;
        image_ack = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check_reset_outputs("idle");

        // Counting pattern: chunk k carries k.
        for (int k = 0; k < NC; k++) ch[k] = DW'(k);
        send_frame(NC, 1'b0);
        check("count_chunk0", IW'(image_data[6:0]), IW'(0));
        check("count_chunk1", IW'(image_data[13:7]), IW'(1));
        check("count_chunk27", IW'(image_data[195:189]), IW'(27));
        frame_en = 1'b0;
        hold_ready(10, 1'b0);
        do_ack();

        // All ones.
        for (int k = 0; k < NC; k++) ch[k] = 7'h7F;
        send_frame(NC, 1'b0);
        check("all_ones", image_data, {IW{1'b1}});
        frame_en = 1'b0;
        do_ack();

        // Abort after 13 chunks, then a normal frame.
        for (int k = 0; k < NC; k++) ch[k] = DW'($urandom);
        send_frame(13, 1'b1);
        for (int k = 0; k < NC; k++) ch[k] = DW'($urandom);
        send_frame(NC, 1'b0);
        frame_en = 1'b0;
        do_ack();

        // frame_en held for 40 cycles, then a fresh edge during READY.
        for (int k = 0; k < NC; k++) ch[k] = DW'($urandom);
        send_frame(NC, 1'b0);
        hold_ready(12, 1'b0);
        frame_en = 1'b0;
        hold_ready(1, 1'b0);
        frame_en = 1'b1;
        hold_ready(5, 1'b0);
        do_ack();

        // Reset at chunk 20 with frame_en held high across release.
        for (int k = 0; k < NC; k++) ch[k] = DW'($urandom);
        send_frame(20, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 4; i++) begin
            step();
            check("held_after_reset_busy", IW'(busy), IW'(0));
        end
        frame_en = 1'b0;
        step();
        for (int k = 0; k < NC; k++) ch[k] = DW'($urandom);
        send_frame(NC, 1'b0);
        frame_en = 1'b0;
        do_ack();

        // Randomized frames and aborts.
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < NC; k++) ch[k] = DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                send_frame(int'($urandom_range(1, NC - 1)), 1'b1);
            end else begin
                send_frame(NC, 1'b0);
                hold_ready(int'($urandom_range(0, 6)), 1'b1);
                do_ack();
            end
            frame_en = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        step();
        check("img_queue_empty", IW'(exp_img_q.size()), IW'(0));
        check("err_queue_empty", IW'(exp_err_q.size()), IW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
